// File: rtl/count_monitor.sv
// Passive self-check for a free-running up-counter: predicts each count sample
// from the previous one and reports mismatches, sticky errors and legal wraps.
module count_monitor #(
  parameter int NUM_BITS     = 8,
  parameter int ERR_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ctr_reset,
  input  logic                    enable,
  input  logic [NUM_BITS-1:0]     count,
  input  logic                    clear,
  output logic                    locked,
  output logic                    mismatch,
  output logic                    error,
  output logic [ERR_CNT_BITS-1:0] err_count,
  output logic                    wrap,
  output logic [NUM_BITS-1:0]     expected
);

  localparam logic S_SYNC  = 1'b0;
  localparam logic S_TRACK = 1'b1;

  localparam logic [NUM_BITS-1:0]     CNT_MAX = '1;
  localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = '1;

  logic                state;
  logic                prev_at_max;
  logic [NUM_BITS-1:0] prediction;
  logic                differ;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    prediction = count;
    if (ctr_reset) begin
      prediction = '0;
    end else if (enable) begin
      prediction = count + 1'b1;
    end
    differ = (count != expected);
  end

  // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_SYNC;
      expected    <= '0;
      mismatch    <= 1'b0;
      error       <= 1'b0;
      err_count   <= '0;
      wrap        <= 1'b0;
      prev_at_max <= 1'b0;
    end else begin
      // A sample at all-ones that is enabled and not reset must legally wrap to 0.
      prev_at_max <= (count == CNT_MAX) && enable && !ctr_reset;
      expected    <= prediction;
      if (clear) begin
        state     <= S_SYNC;
        mismatch  <= 1'b0;
        error     <= 1'b0;
        err_count <= '0;
        wrap      <= 1'b0;
      end else if (state == S_SYNC) begin
        state    <= S_TRACK;
        mismatch <= 1'b0;
        wrap     <= 1'b0;
      end else begin
        // Reloading from the observed sample resyncs, so one fault gives one mismatch.
        mismatch <= differ;
        wrap     <= prev_at_max && (count == '0) && !differ;
        if (differ) begin
          error <= 1'b1;
          if (err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
          end
        end
      end
    end
  end

  assign locked = (state == S_TRACK);

endmodule

// File: tb/tb_count_monitor.sv
// Directed and randomized bench for count_monitor, checked against a
// behavioural model of the counter contract kept in the bench.
module tb_count_monitor;

  logic       clk;
  logic       reset;
  logic       ctr_reset;
  logic       enable;
  logic [7:0] count;
  logic       clear;
  logic       locked;
  logic       mismatch;
  logic       error;
  logic [7:0] err_count;
  logic       wrap;
  logic [7:0] expected;

  count_monitor #(.NUM_BITS(8), .ERR_CNT_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .ctr_reset (ctr_reset),
    .enable    (enable),
    .count     (count),
    .clear     (clear),
    .locked    (locked),
    .mismatch  (mismatch),
    .error     (error),
    .err_count (err_count),
    .wrap      (wrap),
    .expected  (expected)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int wrap_seen = 0;

  // Behavioural counter that produces the observed count.
  logic [7:0] ctr = 8'd0;

  // Reference model of what the monitor should report.
  bit   m_locked = 1'b0;
  int   m_exp = 0;
  bit   m_err = 1'b0;
  int   m_cnt = 0;
  bit   m_mis = 1'b0;
  bit   m_wrap = 1'b0;
  int   p_count = -1;
  bit   p_en = 1'b0;
  bit   p_cr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check every output after the edge.
  task automatic cyc(input bit rst, input bit cr, input bit en, input bit clr,
                     input bit glitch = 1'b0, input logic [7:0] gval = 8'h00);
    int smp;
    int pred;
    bit bad;
    smp = glitch ? int'(gval) : int'(ctr);
    reset     = rst;
    ctr_reset = cr;
    enable    = en;
    clear     = clr;
    count     = 8'(smp);
    pred = cr ? 0 : (en ? (smp + 1) % 256 : smp);
    if (!rst) begin
      m_locked = 0; m_exp = 0; m_err = 0; m_cnt = 0; m_mis = 0; m_wrap = 0;
    end else if (clr) begin
      m_locked = 0; m_exp = pred; m_err = 0; m_cnt = 0; m_mis = 0; m_wrap = 0;
    end else if (!m_locked) begin
      m_locked = 1; m_exp = pred; m_mis = 0; m_wrap = 0;
    end else begin
      bad    = (smp != m_exp);
      m_mis  = bad;
      if (bad) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_wrap = !bad && p_count == 255 && p_en && !p_cr && smp == 0;
      m_exp  = pred;
    end
    p_count = smp; p_en = en; p_cr = cr;
    @(posedge clk);
    #1;
    chk("locked",    32'(locked),    32'(m_locked));
    chk("mismatch",  32'(mismatch),  32'(m_mis));
    chk("error",     32'(error),     32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    chk("wrap",      32'(wrap),      32'(m_wrap));
    chk("expected",  32'(expected),  32'(m_exp));
    if (wrap === 1'b1) wrap_seen++;
    if (cr) ctr = 8'd0;
    else if (en) ctr = ctr + 8'd1;
  endtask

  initial begin
    int r;
    reset = 1'b0; ctr_reset = 1'b1; enable = 1'b0; clear = 1'b0; count = 8'd0;

    // Monitor reset, then short enable / pause / enable run.
    repeat (5) cyc(0, 1, 0, 0);
    chk("reset_locked", 32'(locked), 32'd0);
    cyc(1, 1, 0, 0);
    chk("locked_after_sync", 32'(locked), 32'd1);
    repeat (5) cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (5) cyc(1, 0, 1, 0);
    chk("no_errors_run1", 32'(err_count), 32'd0);

    // Long enabled run from zero: exactly one legal wrap.
    cyc(1, 1, 0, 0);
    wrap_seen = 0;
    repeat (300) cyc(1, 0, 1, 0);
    chk("wrap_once", 32'(wrap_seen), 32'd1);
    chk("no_errors_wrap", 32'(error), 32'd0);

    // Counter jumps to 0x10 while the monitor expects 0x05.
    cyc(1, 1, 0, 0);
    repeat (5) cyc(1, 0, 1, 0);
    chk("expect_05", 32'(expected), 32'h05);
    ctr = 8'h10;
    cyc(1, 0, 1, 0);
    chk("fault_mismatch", 32'(mismatch), 32'd1);
    chk("fault_err_count", 32'(err_count), 32'd1);
    chk("resync_11", 32'(expected), 32'h11);
    repeat (3) cyc(1, 0, 1, 0);
    chk("single_mismatch", 32'(err_count), 32'd1);

    // Saturation of the mismatch counter, then clear.
    repeat (300) begin
      ctr = ctr + 8'd7;
      cyc(1, 0, 1, 0);
    end
    chk("saturated", 32'(err_count), 32'd255);
    chk("sticky_error", 32'(error), 32'd1);
    cyc(1, 0, 1, 1);
    chk("clear_count", 32'(err_count), 32'd0);
    chk("clear_unlocked", 32'(locked), 32'd0);
    cyc(1, 0, 1, 0);
    chk("relock", 32'(locked), 32'd1);

    // Counter reset together with enable at 0x2A.
    cyc(1, 1, 0, 0);
    repeat (42) cyc(1, 0, 1, 0);
    chk("at_2a", 32'(ctr), 32'h2A);
    cyc(1, 1, 1, 0);
    chk("ctr_reset_dominates", 32'(expected), 32'd0);
    repeat (3) cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    chk("ctr_reset_no_error", 32'(error), 32'd0);

    // Monitor reset on the same edge as a fault.
    ctr = ctr + 8'd3;
    cyc(1, 0, 1, 0);
    chk("pre_reset_err", 32'(err_count), 32'd1);
    cyc(0, 0, 1, 0, 1'b1, 8'hC3);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_mismatch", 32'(mismatch), 32'd0);
    cyc(1, 0, 1, 0);
    repeat (4) cyc(1, 0, 1, 0);

    // Randomized traffic.
    repeat (3000) begin
      r = int'($urandom_range(0, 199));
      if (r == 14) ctr = 8'($urandom);
      cyc(r != 0, r >= 3 && r <= 7, 1'($urandom), r == 1 || r == 2,
          r >= 8 && r <= 12, 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Passive checker for the free-running up-counter's output. It samples the counter's `enable`, `reset` and `count` on every clock edge and predicts the next `count`. It flags every deviation from the counter's contract: +1 per enabled cycle, hold when disabled, 0 after counter reset, modulo 2^NUM_BITS wrap. It sits beside the counter in benches and in the integrated design as a self-check, and drives no signal back into the counter.

## Interface
- NUM_BITS, 8, width of the observed count
- ERR_CNT_BITS, 8, width of the saturating mismatch counter
- clk  in  1  rising-edge clock, same clock as the counter
- reset  in  1  synchronous, active-low monitor reset (0 = reset)
- ctr_reset  in  1  the counter's own reset, active-high, observed only
- enable  in  1  the counter's enable, observed only
- count  in  NUM_BITS  the counter's output, observed only
- clear  in  1  synchronous: zero error state and re-acquire lock
- locked  out  1  monitor holds a valid prediction
- mismatch  out  1  one-cycle pulse: sampled count differed from prediction
- error  out  1  sticky: set on any mismatch, cleared by reset or clear
- err_count  out  ERR_CNT_BITS  number of mismatches, saturating
- wrap  out  1  one-cycle pulse: legal wrap from all-ones to 0 observed
- expected  out  NUM_BITS  prediction for the count sample at the next edge

## Operation
- Registered state: FSM {SYNC, TRACK}, plus `expected`, `error`, `err_count` and the `mismatch`/`wrap` pulse flops.
- Prediction rule, computed from the current sample:
  - if ctr_reset=1: next expected = 0
  - else if enable=1: next expected = count+1 mod 2^NUM_BITS
  - else: next expected = count
- SYNC: no comparison is made. Load `expected` from the prediction rule, then go to TRACK. `locked` = 0.
- TRACK: compare the sampled `count` against registered `expected`.
  - Equal: no mismatch; `expected` is reloaded from the prediction rule.
  - Unequal: `mismatch` pulses, `error` is set, `err_count` increments (holds at 2^ERR_CNT_BITS-1). The monitor resyncs: `expected` is reloaded from the prediction rule applied to the observed sample, so one fault produces one mismatch, not a cascade. The FSM stays in TRACK.
- `wrap` pulses in TRACK when all of these hold: the previous sample had count = 2^NUM_BITS-1, enable=1 and ctr_reset=0; the current sample has count = 0; and there is no mismatch on the current sample.
- `clear` (only while reset=1): `error`=0, `err_count`=0, FSM goes to SYNC, no compare on that edge, pulses forced to 0.
- Priority on the same edge: reset > clear > mismatch update.
- `locked` = (state == TRACK).

## Timing
- All outputs are registered and change only on the rising clk edge.
- Latency: a bad sample captured at edge k produces `mismatch`=1 (and the updated `err_count`/`error`) during the cycle after edge k. The same latency applies to `wrap`.
- `locked` rises one cycle after reset is deasserted or clear is dropped (one SYNC cycle).
- Reset values (reset=0 at an edge): state=SYNC, locked=0, mismatch=0, error=0, err_count=0, wrap=0, expected=0.
- Reset mid-operation: it takes effect on the next edge regardless of state. No mismatch is reported for the sample taken during reset.
- Simultaneous clear and mismatch: clear wins, err_count=0, mismatch=0.
- Simultaneous ctr_reset and enable: prediction is 0 (counter reset dominates).
- Inputs must be sampled on the same edge at which the counter updates. The counter's count is the registered value preceding that edge.

## Test plan
- Monitor reset low 5 cycles, then high; counter reset 10 ns, enable 50 ns, pause 10 ns, enable 50 ns -> locked=1 from the 2nd cycle after reset release, mismatch never 1, err_count=0, expected tracks count+enable each cycle.
- Enable held for 300 cycles from count=0 -> exactly one wrap pulse, one cycle after count=0 is sampled following 255, no mismatch.
- Force count=8'h10 for one cycle while expected=8'h05 -> one mismatch pulse, err_count=1, error=1; next cycles predict 8'h11 and report no further mismatch.
- Inject 300 single-cycle faults with ERR_CNT_BITS=8 -> err_count saturates at 255, error stays 1; then clear for 1 cycle -> err_count=0, error=0, locked=0 one cycle, then 1.
- Counter ctr_reset=1 with enable=1 at count=8'h2A -> next sample 0 is accepted, expected=0 while held in reset, no mismatch.
- Assert monitor reset mid-run with a fault injected on the same edge -> all outputs return to reset values; no mismatch pulse or err_count increment from that sample.
